// File: rtl/koala_pkg.sv
// koala_pkg: width constants and loader types shared by the Koala-P datapath
// (absorb loader and permutation stage), plus small byte-lane helpers.
package koala_pkg;

  localparam int KOALA_B         = 257;
  localparam int KOALA_DATA_BITS = 256;
  localparam int KOALA_WORD_W    = 32;
  localparam int KOALA_BLK_WORDS = 8;

  typedef enum logic [0:0] {
    FILL = 1'b0,
    HOLD = 1'b1
  } koala_ld_state_e;

  // Bytes of a word that carry message data: only a tail word may be short,
  // and anything above 4 saturates to a full word.
  function automatic logic [2:0] koala_eff_bytes(input logic [2:0] bytes,
                                                 input logic       last);
    logic [2:0] eff;
    if (last && (bytes < 3'd4)) begin
      eff = bytes;
    end else begin
      eff = 3'd4;
    end
    return eff;
  endfunction

  // Lane mask keeping the low nbytes bytes of a 32-bit word.
  function automatic logic [31:0] koala_byte_mask(input logic [2:0] nbytes);
    logic [31:0] m;
    m = 32'h0000_0000;
    for (int i = 0; i < 4; i++) begin
      if (3'(i) < nbytes) begin
        m[8*i +: 8] = 8'hFF;
      end else begin
        m[8*i +: 8] = 8'h00;
      end
    end
    return m;
  endfunction

endpackage

// File: rtl/koala_blk_buf.sv
// koala_blk_buf: single-entry valid/ready holding register for one block plus
// its final flag. Accepts a new entry in the same cycle the old one drains.
module koala_blk_buf
  import koala_pkg::*;
#(
  parameter int W = KOALA_B + 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic [W-1:0] in_data_i,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [W-1:0] out_data_o
);

  logic         valid_q, valid_d;
  logic [W-1:0] data_q, data_d;

  assign in_ready_o  = !valid_q || out_ready_i;
  assign out_valid_o = valid_q;
  assign out_data_o  = data_q;

  // Next entry: load on an input handshake, empty on a drain, else hold.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (in_valid_i && in_ready_o) begin
      valid_d = 1'b1;
      data_d  = in_data_i;
    end else if (out_ready_i) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end
  end

  // Entry register with synchronous clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= {W{1'b0}};
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

endmodule

// File: rtl/koala_absorb_loader.sv
// koala_absorb_loader: packs 32-bit message words into 257-bit Koala-P blocks,
// pads the final block (single 1 bit right after the data) and hands blocks
// out on a valid/ready port.
// Optional build macro KOALA_LOADER_SKID_EN: adds a second block register so
// filling continues while the output waits on the consumer.
module koala_absorb_loader
  import koala_pkg::*;
#(
  parameter int WORD_W    = KOALA_WORD_W,
  parameter int BLK_WORDS = KOALA_BLK_WORDS
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WORD_W-1:0]  in_data,
  input  logic [2:0]         in_bytes,
  input  logic               in_last,
  output logic               blk_valid,
  input  logic               blk_ready,
  output logic [KOALA_B-1:0] blk_data,
  output logic               blk_final
);

  localparam int CNT_W = $clog2(BLK_WORDS);

  koala_ld_state_e            state_q, state_d;
  logic [KOALA_DATA_BITS-1:0] acc_q, acc_d;
  logic [CNT_W-1:0]           cnt_q, cnt_d;

  logic                accept_s, close_s, in_ready_s, room_s;
  logic                hold_enter_s, hold_release_s;
  logic [2:0]          eff_bytes_s;
  logic [WORD_W-1:0]   word_masked_s;
  logic [8:0]          pad_idx_s;
  logic [KOALA_B-1:0]  placed_s, pad_vec_s, closed_blk_s;
  logic                out_in_valid_s, out_in_ready_s, out_valid_s;
  logic [KOALA_B:0]    out_in_data_s, out_data_s;

  assign in_ready = in_ready_s;
  assign accept_s = in_valid && in_ready_s;
  assign close_s  = accept_s && (in_last || (cnt_q == CNT_W'(BLK_WORDS - 1)));

  // Packing: mask the tail bytes, place the word in its slot, build the pad bit.
  always_comb begin
    eff_bytes_s   = koala_eff_bytes(in_bytes, in_last);
    word_masked_s = in_data & koala_byte_mask(eff_bytes_s);
    placed_s      = {{(KOALA_B-WORD_W){1'b0}}, word_masked_s} << {cnt_q, 5'b00000};
    // Pad position is 8 * (data bytes in block) = 32*cnt + 8*bytes_this_word.
    pad_idx_s     = {1'b0, cnt_q, 5'b00000} + {3'b000, eff_bytes_s, 3'b000};
    if (in_last) begin
      pad_vec_s = {{(KOALA_B-1){1'b0}}, 1'b1} << pad_idx_s;
    end else begin
      pad_vec_s = {KOALA_B{1'b0}};
    end
    closed_blk_s = {1'b0, acc_q} | placed_s | pad_vec_s;
  end

  // Fill register next state: the closed block leaves with its closing word,
  // so the fill register is already clear when the block is handed out.
  always_comb begin
    acc_d = acc_q;
    cnt_d = cnt_q;
    if (close_s) begin
      acc_d = {KOALA_DATA_BITS{1'b0}};
      cnt_d = {CNT_W{1'b0}};
    end else if (accept_s) begin
      acc_d = acc_q | placed_s[KOALA_DATA_BITS-1:0];
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      acc_d = acc_q;
      cnt_d = cnt_q;
    end
  end

  // Fill register and word counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= {KOALA_DATA_BITS{1'b0}};
      cnt_q <= {CNT_W{1'b0}};
    end else begin
      acc_q <= acc_d;
      cnt_q <= cnt_d;
    end
  end

`ifdef KOALA_LOADER_SKID_EN
  logic             skid_valid_s, skid_in_ready_s;
  logic [KOALA_B:0] skid_data_s;

  // A closed block parks here only when the output register cannot take it.
  koala_blk_buf #(.W(KOALA_B + 1)) u_skid (
    .clk         (clk),
    .rst         (rst),
    .in_valid_i  (close_s && !out_in_ready_s),
    .in_ready_o  (skid_in_ready_s),
    .in_data_i   ({in_last, closed_blk_s}),
    .out_valid_o (skid_valid_s),
    .out_ready_i (out_in_ready_s),
    .out_data_o  (skid_data_s)
  );

  assign room_s         = skid_in_ready_s;
  assign hold_enter_s   = close_s && !out_in_ready_s;
  assign hold_release_s = out_in_ready_s;

  // Output feed: a parked block goes first, otherwise the freshly closed one.
  always_comb begin
    if (skid_valid_s) begin
      out_in_valid_s = 1'b1;
      out_in_data_s  = skid_data_s;
    end else begin
      out_in_valid_s = close_s;
      out_in_data_s  = {in_last, closed_blk_s};
    end
  end
`else
  assign room_s         = out_in_ready_s;
  assign hold_enter_s   = close_s;
  assign hold_release_s = out_valid_s && blk_ready;

  // Output feed: the closed block goes straight to the output register.
  always_comb begin
    out_in_valid_s = close_s;
    out_in_data_s  = {in_last, closed_blk_s};
  end
`endif

  // Output register driving the permutation state input.
  koala_blk_buf #(.W(KOALA_B + 1)) u_out (
    .clk         (clk),
    .rst         (rst),
    .in_valid_i  (out_in_valid_s),
    .in_ready_o  (out_in_ready_s),
    .in_data_i   (out_in_data_s),
    .out_valid_o (out_valid_s),
    .out_ready_i (blk_ready),
    .out_data_o  (out_data_s)
  );

  assign blk_valid = out_valid_s;
  assign blk_data  = out_data_s[KOALA_B-1:0];
  assign blk_final = out_data_s[KOALA_B];

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FILL;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state: HOLD while a closed block blocks further filling.
  always_comb begin
    state_d = state_q;
    case (state_q)
      FILL: begin
        if (hold_enter_s) begin
          state_d = HOLD;
        end else begin
          state_d = FILL;
        end
      end
      HOLD: begin
        if (hold_release_s) begin
          state_d = FILL;
        end else begin
          state_d = HOLD;
        end
      end
      default: state_d = FILL;
    endcase
  end

  // FSM outputs: accept words only in FILL and never while reset is high.
  always_comb begin
    if (rst) begin
      in_ready_s = 1'b0;
    end else if (state_q == FILL) begin
      in_ready_s = room_s;
    end else begin
      in_ready_s = 1'b0;
    end
  end

endmodule

// File: tb/tb_koala_absorb_loader.sv
// Testbench for koala_absorb_loader: reset checks, a table of single-word
// messages, hand-written multi-cycle sequences, then random messages checked
// against a byte-queue reference model.
module tb_koala_absorb_loader;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [31:0]  in_data;
  logic [2:0]   in_bytes;
  logic         in_last;
  logic         blk_valid;
  logic         blk_ready;
  logic [256:0] blk_data;
  logic         blk_final;

  always #5 clk = ~clk;

  koala_absorb_loader dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_bytes  (in_bytes),
    .in_last   (in_last),
    .blk_valid (blk_valid),
    .blk_ready (blk_ready),
    .blk_data  (blk_data),
    .blk_final (blk_final)
  );

`ifdef KOALA_LOADER_SKID_EN
  localparam logic RDY_WHILE_HELD = 1'b1;
`else
  localparam logic RDY_WHILE_HELD = 1'b0;
`endif

  typedef struct {
    logic [256:0] blk;
    logic         fin;
  } blk_t;

  typedef struct {
    logic [31:0]  d;
    logic [2:0]   nb;
    logic [256:0] blk;
  } vec_t;

  blk_t         exp_q[$];
  logic [7:0]   cur_bytes[$];
  int           cur_words = 0;
  int           total = 0;
  int           bad = 0;
  bit           auto_rdy = 1'b0;
  bit           held = 1'b0;
  logic [256:0] held_data;
  logic         held_fin;

  task automatic check(input string name, input logic [256:0] act, input logic [256:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  // ---------------- reference model (message bytes per block) ----------------
  task automatic model_reset();
    cur_bytes.delete();
    cur_words = 0;
  endtask

  task automatic model_emit(input logic fin);
    blk_t e;
    e.blk = '0;
    foreach (cur_bytes[i]) e.blk[8*i +: 8] = cur_bytes[i];
    if (fin) e.blk[8*cur_bytes.size()] = 1'b1;
    e.fin = fin;
    exp_q.push_back(e);
    model_reset();
  endtask

  task automatic model_word(input logic [31:0] d, input logic [2:0] nb, input logic last);
    int n;
    n = (last && nb < 3'd4) ? int'(nb) : 4;
    for (int i = 0; i < n; i++) cur_bytes.push_back(d[8*i +: 8]);
    cur_words++;
    if (last) model_emit(1'b1);
    else if (cur_words == 8) model_emit(1'b0);
  endtask

  // ---------------- clocking helpers ----------------
  // Advance to the next falling edge; in auto mode also drive a random
  // blk_ready and score every block that will be taken at the next rising edge.
  task automatic tick();
    blk_t e;
    @(negedge clk);
    if (auto_rdy) begin
      if (held) begin
        check("held_valid", blk_valid, 1'b1);
        check("held_data", blk_data, held_data);
        check("held_final", blk_final, held_fin);
      end
      blk_ready = ($urandom_range(0, 3) != 0);
      if (blk_valid && blk_ready) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL extra_block: got block %h, required none", blk_data);
        end else begin
          e = exp_q.pop_front();
          check("rnd_data", blk_data, e.blk);
          check("rnd_final", blk_final, e.fin);
        end
      end
      held      = blk_valid && !blk_ready;
      held_data = blk_data;
      held_fin  = blk_final;
    end
  endtask

  task automatic send(input logic [31:0] d, input logic [2:0] nb, input logic last);
    int guard;
    guard    = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_bytes = nb;
    in_last  = last;
    while (in_ready !== 1'b1 && guard < 200) begin
      tick();
      guard++;
    end
    if (in_ready !== 1'b1) begin
      total++;
      bad++;
      $display("FAIL send_timeout: in_ready=%b, required 1", in_ready);
    end else begin
      model_word(d, nb, last);
    end
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_data  = $urandom();
    in_bytes = 3'($urandom_range(0, 7));
  endtask

  task automatic take();
    blk_ready = 1'b1;
    tick();
    blk_ready = 1'b0;
  endtask

  task automatic expect_blk(input string name, input logic [256:0] blk, input logic fin);
    check({name, "_valid"}, blk_valid, 1'b1);
    check({name, "_data"}, blk_data, blk);
    check({name, "_final"}, blk_final, fin);
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation still running, required finish");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t         vecs[8];
    logic [256:0] e;
    int           nwords;

    rst = 1'b1; in_valid = 1'b0; in_data = 32'h0; in_bytes = 3'd0;
    in_last = 1'b0; blk_ready = 1'b0;

    vecs[0] = '{32'hAABBCCDD, 3'd3, 257'h01BBCCDD};
    vecs[1] = '{32'hAABBCCDD, 3'd0, 257'h1};
    vecs[2] = '{32'hAABBCCDD, 3'd1, 257'h1DD};
    vecs[3] = '{32'hAABBCCDD, 3'd2, 257'h1CCDD};
    vecs[4] = '{32'hAABBCCDD, 3'd4, 257'h1AABBCCDD};
    vecs[5] = '{32'h12345678, 3'd7, 257'h112345678};
    vecs[6] = '{32'hFFFFFFFF, 3'd5, 257'h1FFFFFFFF};
    vecs[7] = '{32'h0000FF00, 3'd2, 257'h1FF00};

    // Reset state.
    tick();
    tick();
    check("rst_in_ready", in_ready, 1'b0);
    check("rst_blk_valid", blk_valid, 1'b0);
    check("rst_blk_data", blk_data, 257'h0);
    check("rst_blk_final", blk_final, 1'b0);
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", in_ready, 1'b1);

    // Single-word messages from the table.
    for (int i = 0; i < 8; i++) begin
      send(vecs[i].d, vecs[i].nb, 1'b1);
      expect_blk($sformatf("tbl%0d", i), vecs[i].blk, 1'b1);
      check($sformatf("tbl%0d_in_ready_held", i), in_ready, RDY_WHILE_HELD);
      take();
      check($sformatf("tbl%0d_valid_after", i), blk_valid, 1'b0);
      check($sformatf("tbl%0d_turnaround", i), in_ready, 1'b1);
    end

    // 32-byte message: full final block, pad lands in bit 256.
    e = '0;
    for (int k = 0; k < 8; k++) begin
      send(32'(k), 3'd4, k == 7);
      if (k == 6) check("b32_no_early", blk_valid, 1'b0);
      e[32*k +: 32] = 32'(k);
    end
    e[256] = 1'b1;
    expect_blk("b32", e, 1'b1);
    take();

    // 36-byte message: full non-final block, then a one-word padded block.
    e = '0;
    for (int k = 0; k < 8; k++) begin
      send(32'hA0000000 + 32'(k), 3'd1, 1'b0);
      e[32*k +: 32] = 32'hA0000000 + 32'(k);
    end
    expect_blk("b36_blk1", e, 1'b0);
    check("b36_in_ready_held", in_ready, RDY_WHILE_HELD);
    take();
    check("b36_turnaround", in_ready, 1'b1);
    send(32'h11223344, 3'd4, 1'b1);
    expect_blk("b36_blk2", 257'h111223344, 1'b1);
    take();

    // Backpressure: block held stable for 5 cycles.
    send(32'hDEADBEEF, 3'd0, 1'b1);
    for (int c = 0; c < 5; c++) begin
      tick();
      expect_blk($sformatf("bp%0d", c), 257'h1, 1'b1);
      check($sformatf("bp%0d_in_ready", c), in_ready, RDY_WHILE_HELD);
    end
`ifdef KOALA_LOADER_SKID_EN
    e = '0;
    for (int k = 0; k < 8; k++) begin
      send(32'hC0DE0000 + 32'(k), 3'd4, 1'b0);
      e[32*k +: 32] = 32'hC0DE0000 + 32'(k);
    end
    check("skid_full_in_ready", in_ready, 1'b0);
    take();
    expect_blk("skid_second", e, 1'b0);
`endif
    take();
    check("bp_drained", blk_valid, 1'b0);

    // Reset mid-block discards the partial block.
    for (int k = 0; k < 4; k++) send(32'h55550000 + 32'(k), 3'd4, 1'b0);
    rst = 1'b1;
    tick();
    check("midrst_in_ready_in_rst", in_ready, 1'b0);
    check("midrst_valid", blk_valid, 1'b0);
    rst = 1'b0;
    #1;
    check("midrst_in_ready", in_ready, 1'b1);
    model_reset();
    send(32'h99999999, 3'd0, 1'b1);
    expect_blk("midrst_empty", 257'h1, 1'b1);

    // Reset while a block is held drops it.
    rst = 1'b1;
    tick();
    check("holdrst_valid", blk_valid, 1'b0);
    check("holdrst_data", blk_data, 257'h0);
    rst = 1'b0;
    #1;
    check("holdrst_in_ready", in_ready, 1'b1);
    exp_q.delete();
    model_reset();

    // Random messages against the reference model.
    auto_rdy = 1'b1;
    held     = 1'b0;
    for (int m = 0; m < 40; m++) begin
      nwords = $urandom_range(1, 18);
      for (int w = 0; w < nwords; w++) begin
        for (int g = $urandom_range(0, 2); g > 0; g--) tick();
        if (w == nwords - 1) send($urandom(), 3'($urandom_range(0, 7)), 1'b1);
        else send($urandom(), 3'($urandom_range(0, 7)), 1'b0);
      end
    end
    for (int g = 0; g < 500 && exp_q.size() > 0; g++) tick();
    check("rnd_all_blocks_seen", exp_q.size(), 0);
    auto_rdy = 1'b0;
    tick();
    blk_ready = 1'b0;
    check("rnd_idle_valid", blk_valid, 1'b0);
    check("rnd_idle_in_ready", in_ready, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/koala_absorb_loader.md
# koala_absorb_loader

Input-side loader directly upstream of the Koala-P permutation. It accepts a message as 32-bit words over a valid/ready stream and packs them into 257-bit blocks. The final block is padded. Each block goes out on a valid/ready port that drives the permutation's 257-bit state input, with a flag marking the final block.

## Interface
Parameters:
- WORD_W, 32, input word width; fixed at 32, other values unsupported.
- BLK_WORDS, 8, data words per block (256 data bits).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  input word valid.
- in_ready  out  1  loader accepts a word this cycle.
- in_data  in  32  message word; byte 0 = in_data[7:0].
- in_bytes  in  3  valid bytes in word (0..4). Honoured only with in_last; otherwise treated as 4. Values >4 are treated as 4.
- in_last  in  1  word is the message tail.
- blk_valid  out  1  blk_data/blk_final valid.
- blk_ready  in  1  consumer (permutation stage) accepts the block.
- blk_data  out  257  packed block.
- blk_final  out  1  block is the padded final block.

## Operation
- A handshake occurs on a side when valid && ready are both high in the same cycle.
- Packing:
  - Accepted word k (0..7) of the current block lands in bits [32k+31:32k].
  - Unused bytes of a partial tail word are forced to zero, whatever in_data holds.
- Block completion:
  - On the 8th accepted word without in_last, the block closes non-final.
  - Non-final block: bit 256 = 0, blk_final = 0.
- Padding (final block):
  - Let n = bytes of data in the final block (0..32).
  - Bit 8n = 1; all bits above 8n = 0.
  - A full final block (n = 32) therefore has bit 256 = 1.
  - in_last with in_bytes = 0 closes the block with no new data bytes.
  - This covers both the empty message and a tail that starts after a full non-final block.
- FSM states:
  - FILL: in_ready = 1. Accept words. Go to HOLD when the block closes (8th word or in_last).
  - HOLD: in_ready = 0, blk_valid = 1. On a blk_ready handshake:
    - clear the block register and word counter;
    - return to FILL.
- blk_data and blk_final stay stable while blk_valid && !blk_ready.
- No block is ever emitted without a closing event; a message in progress does not time out.

## Timing
- Reset (rst high at a clock edge):
  - state = FILL, word count = 0, block register = 0;
  - blk_valid = 0, blk_final = 0, blk_data = 0.
  - in_ready = 0 during any cycle with rst high; it is 1 in the first cycle after rst deasserts.
- Latency: blk_valid rises the cycle after the handshake of the closing word.
- Turnaround (build without buffering): after the blk_ready handshake, in_ready is 1 in the next cycle. This gives one idle input cycle per block.
- Throughput: one word per cycle in FILL.
- Reset mid-operation:
  - A partially filled block or a held block is discarded.
  - blk_valid drops the cycle after the rst edge.
- in_valid with in_ready = 0 has no effect; the upstream source must hold its word.

## Configuration
- KOALA_LOADER_SKID_EN defined:
  - A second 257-bit register (plus final flag) sits between the fill register and the output.
  - A closed block moves to it when it is empty, so in_ready stays 1 while the output waits.
  - in_ready drops only when the output register is occupied and the fill register has closed a block.
  - Move and output handshake in the same cycle: no bubble. The back-to-back rate is 8 words per block.
- Undefined: a single register and the two-state FSM above, with one idle input cycle per block.

## Structure
- Shared package koala_pkg holds:
  - KOALA_B = 257, KOALA_DATA_BITS = 256, KOALA_WORD_W = 32, KOALA_BLK_WORDS = 8;
  - the loader state enum {FILL, HOLD}.
  - The permutation stage uses the same width constants.
- One sub-module, koala_blk_buf: a single-entry 258-bit valid/ready holding register.
  - The output register is one instance.
  - Under KOALA_LOADER_SKID_EN a second instance is added.
- Packing, byte masking and padding stay in the top module.

## Test plan
- Empty message: one word, in_last = 1, in_bytes = 0 -> one block, blk_data = 1 (bit 0 only), blk_final = 1, one cycle after the handshake.
- 3-byte message: in_data = 0xAABBCCDD, in_bytes = 3, last -> blk_data = 0x01BBCCDD (bits 24 set, 31:25 zero), final.
- 32-byte message: words 0x00000000..0x00000007, last on word 7 with in_bytes = 4 -> bits [255:0] = the words, bit 256 = 1, final.
- 36-byte message: 8 full words then 0x11223344 last with in_bytes = 4:
  - block 1: bit 256 = 0, blk_final = 0;
  - block 2: bits [31:0] = 0x11223344, bit 32 = 1, blk_final = 1.
- Backpressure: hold blk_ready = 0 for 5 cycles -> blk_data stable and in_ready = 0 (unbuffered build). With KOALA_LOADER_SKID_EN, in_ready stays 1 until a second block closes.
- Reset mid-block: accept 4 words, pulse rst -> next cycle blk_valid = 0, in_ready = 1. A following 1-word empty-tail message yields blk_data = 1.
